bta_op_scheduler: RTL and testbench
===================================

Name: bta_op_scheduler

Overview:
Sequencer for the 32-operand binary-tree CLA adder. Accepts 16-bit operands serially over a valid/ready stream and packs them into the adder's operand slots. Zero-pads when a burst ends early via in_last, then waits out the adder's pipeline latency. Presents the captured sum on a valid/ready result port; the adder itself stays external.

Parameters:
N, 32, number of adder operand slots (power of 2, multiple of 8)
M, 16, operand width in bits
LAT, 2, clock cycles from stable operand buses to valid adder_sum/adder_carry (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  scheduler can accept operand
in_data  in  M  operand value (unsigned)
in_last  in  1  final operand of burst
adder_ops  out  N*M  packed operands; slot k at [k*M +: M]; bus A = bits [N*M/8-1:0], bus H = top eighth
adder_cin  out  1  adder carry-in, tied 0
adder_sum  in  M+log2(N)  adder sum output
adder_carry  in  1  adder carry output
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_sum  out  M+log2(N)+1  {adder_carry, adder_sum} captured
out_count  out  log2(N)+1  operands in this result (1..N)
busy  out  1  high whenever state != COLLECT or slot index != 0

Behaviour:
- Reset (rst=1 at clk edge): state=COLLECT, idx=0, operand register all 0, out_valid=0, out_sum=0, out_count=0, in_ready=1 (next cycle), busy=0, latency counter=0. Reset overrides any state, including mid-burst and mid-COMPUTE; partial operands are discarded.
- COLLECT: in_ready=1.
  - On in_valid&in_ready: write in_data to slot idx; idx++.
  - If idx==N-1 or in_last: go to COMPUTE, latch out_count=idx+1, load counter=LAT.
  - Slots not written keep 0.
- COMPUTE: in_ready=0; adder_ops held stable; counter decrements each cycle. When counter reaches 1, capture out_sum={adder_carry,adder_sum} at that edge, set out_valid=1, go to DONE. Capture occurs exactly LAT cycles after the edge that wrote the final operand.
- DONE: out_valid=1, out_sum/out_count stable, in_ready=0. On out_valid&out_ready: out_valid=0, operand register cleared to 0, idx=0, go to COLLECT. in_ready is 1 the following cycle; no same-cycle accept.
- Handshake rules:
  - in_ready independent of in_valid.
  - out_valid, once high, stays high with stable data until accepted.
  - in_last on a beat with idx==N-1 is redundant and is not an error.
  - in_last without in_valid is ignored.
- Width: out_sum max N*(2^M-1) fits in M+log2(N) bits; MSB (carry) is expected 0 and passed through unmodified for checking.
- adder_cin constant 0.
- Throughput: one result per (beats + LAT + 1 + handshake) cycles; no overlap of bursts.

Test Plan:
- 32 beats of 16'hFFFF, in_last on beat 32, out_ready=1 -> out_sum=22'h1FFFE0, out_count=32, carry bit 0; out_valid exactly LAT cycles after last beat.
- Beats 1..32 (no in_last) -> auto-transition at beat 32; out_sum=528 (0x210), out_count=32.
- Beats 5,7,9 with in_last on 9 -> slots 3..31 zero; out_sum=21, out_count=3.
- Single beat 16'h1234 with in_last -> out_sum=0x1234, out_count=1. A follow-up burst 2,3 (last) -> 5, with no stale slot contamination.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid/out_sum held, in_ready=0 while in_valid asserted; accept on cycle 11 -> in_ready=1 next cycle.
- rst pulsed after 10 beats of 16'h0100, then burst 4,6 (last) -> out_sum=10, out_count=2; rst during COMPUTE -> no out_valid, returns to COLLECT with in_ready=1.

Source files
------------

// File: rtl/bta_op_scheduler.sv
// Operand sequencer for the external N-operand binary-tree CLA adder.
// It packs serial operands into slots, waits out the adder latency and then holds the captured sum for the consumer.
module bta_op_scheduler #(
  parameter int unsigned N   = 32,
  parameter int unsigned M   = 16,
  parameter int unsigned LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [M-1:0]             in_data,
  input  logic                     in_last,
  output logic [N*M-1:0]           adder_ops,
  output logic                     adder_cin,
  input  logic [M+$clog2(N)-1:0]   adder_sum,
  input  logic                     adder_carry,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [M+$clog2(N):0]     out_sum,
  output logic [$clog2(N):0]       out_count,
  output logic                     busy
);

  localparam int unsigned IW   = $clog2(N);
  localparam int unsigned CW   = IW + 1;
  localparam int unsigned SW   = M + IW + 1;
  localparam int unsigned LATW = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [N*M-1:0]    ops_q, ops_d;
  logic [LATW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]     sum_q, sum_d;
  logic [CW-1:0]     count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_COLLECT;
      idx_q       <= '0;
      ops_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ops_q       <= ops_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ops_d       = ops_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_COLLECT: begin
        if (in_valid && in_ready_q) begin
          ops_d[32'(idx_q) * M +: M] = in_data;
          idx_d = idx_q + IW'(1);
          if ((idx_q == IW'(N - 1)) || in_last) begin
            state_d = S_COMPUTE;
            count_d = CW'(idx_q) + CW'(1);
            cnt_d   = LATW'(LAT);
          end
        end
      end
      S_COMPUTE: begin
        // The final operand landed LAT-cnt_q edges ago; sample on the LAT-th edge.
        if (cnt_q == LATW'(1)) begin
          sum_d       = {adder_carry, adder_sum};
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q - LATW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          ops_d       = '0;
          idx_d       = '0;
          state_d     = S_COLLECT;
        end
      end
      default: begin
        state_d = S_COLLECT;
      end
    endcase

    in_ready_d = (state_d == S_COLLECT);
    busy_d     = (state_d != S_COLLECT) || (idx_d != '0);
  end

  assign adder_ops = ops_q;
  assign adder_cin = 1'b0;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_count = count_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bta_op_scheduler.sv
// Self-checking bench for bta_op_scheduler with a latency-accurate adder model and a result scoreboard.
module tb_bta_op_scheduler;

  localparam int unsigned N   = 32;
  localparam int unsigned M   = 16;
  localparam int unsigned LAT = 2;
  localparam int unsigned SW  = M + $clog2(N);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [M-1:0]      in_data;
  logic              in_last;
  logic [N*M-1:0]    adder_ops;
  logic              adder_cin;
  logic [SW-1:0]     adder_sum;
  logic              adder_carry;
  logic              out_valid;
  logic              out_ready;
  logic [SW:0]       out_sum;
  logic [$clog2(N):0] out_count;
  logic              busy;

  bta_op_scheduler #(.N(N), .M(M), .LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .adder_ops   (adder_ops),
    .adder_cin   (adder_cin),
    .adder_sum   (adder_sum),
    .adder_carry (adder_carry),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_count   (out_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Adder model: combinational sum plus LAT-1 register stages, so the sum is valid exactly LAT edges after the operands change.
  logic [SW:0] comb_sum;
  logic [SW:0] model_q;
  logic        force_carry;
  always_comb begin
    comb_sum = '0;
    for (int k = 0; k < int'(N); k++) comb_sum = comb_sum + (SW+1)'(adder_ops[k*M +: M]);
  end
  always @(posedge clk) model_q <= comb_sum;
  assign adder_sum   = model_q[SW-1:0];
  assign adder_carry = model_q[SW] | force_carry;

  typedef struct {
    int unsigned n;
    logic [15:0] base;
    logic [15:0] step;
    bit          use_last;
    bit          gaps;
    int unsigned stall;
    bit          force_c;
    logic [21:0] exp_sum;
    logic [5:0]  exp_cnt;
  } vec_t;

  typedef struct packed {
    logic [21:0] s;
    logic [5:0]  c;
  } res_t;

  res_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic beat(input logic [15:0] d, input bit last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    chk("in_ready_beat", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int   lat;
    res_t exp_r;
    logic [21:0] held;
    force_carry = v.force_c;
    sb.push_back('{s: v.exp_sum, c: v.exp_cnt});
    for (int k = 0; k < int'(v.n); k++) begin
      if (v.gaps && k > 0) begin
        // Idle cycle with a stray in_last; it must be ignored.
        in_last = 1'b1;
        @(posedge clk); #1;
        in_last = 1'b0;
      end
      beat(v.base + 16'(k) * v.step, v.use_last && (k == int'(v.n) - 1));
    end
    chk($sformatf("v%0d_busy", id), 64'(busy), 64'd1);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("v%0d_latency", id), 64'(lat), 64'(LAT));
    if (sb.size() == 0) begin
      chk($sformatf("v%0d_sb_empty", id), 64'd1, 64'd0);
    end else begin
      exp_r = sb.pop_front();
      chk($sformatf("v%0d_sum", id), 64'(out_sum), 64'(exp_r.s));
      chk($sformatf("v%0d_count", id), 64'(out_count), 64'(exp_r.c));
    end
    held = out_sum;
    if (v.stall > 0) begin
      in_valid = 1'b1;
      in_data  = 16'hDEAD;
      for (int c = 0; c < int'(v.stall); c++) begin
        @(posedge clk); #1;
        chk($sformatf("v%0d_stall_in_ready", id), 64'(in_ready), 64'd0);
        chk($sformatf("v%0d_stall_valid", id), 64'(out_valid), 64'd1);
        chk($sformatf("v%0d_stall_sum", id), 64'(out_sum), 64'(held));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready   = 1'b0;
    force_carry = 1'b0;
    chk($sformatf("v%0d_post_valid", id), 64'(out_valid), 64'd0);
    chk($sformatf("v%0d_post_in_ready", id), 64'(in_ready), 64'd1);
    chk($sformatf("v%0d_post_busy", id), 64'(busy), 64'd0);
    chk($sformatf("v%0d_post_ops", id), 64'(adder_ops == '0), 64'd1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  vec_t vecs[7];
  vec_t vx;
  bit   seen;

  initial begin
    //                n   base      step     last gaps stall fc  exp_sum       cnt
    vecs[0] = '{32, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 10, 1'b0, 22'h1FFFE0, 6'd32};
    vecs[1] = '{32, 16'h0001, 16'h0001, 1'b0, 1'b0, 0,  1'b0, 22'd528,    6'd32};
    vecs[2] = '{3,  16'h0005, 16'h0002, 1'b1, 1'b0, 0,  1'b0, 22'd21,     6'd3};
    vecs[3] = '{1,  16'h1234, 16'h0000, 1'b1, 1'b0, 0,  1'b0, 22'h001234, 6'd1};
    vecs[4] = '{2,  16'h0002, 16'h0001, 1'b1, 1'b0, 0,  1'b0, 22'd5,      6'd2};
    vecs[5] = '{5,  16'h8000, 16'h0010, 1'b1, 1'b1, 3,  1'b0, 22'h0280A0, 6'd5};
    vecs[6] = '{4,  16'd10,   16'h0000, 1'b1, 1'b0, 0,  1'b1, 22'h200028, 6'd4};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b0; force_carry = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ops", 64'(adder_ops == '0), 64'd1);
    chk("adder_cin", 64'(adder_cin), 64'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reset mid-burst discards partial operands.
    for (int k = 0; k < 10; k++) beat(16'h0100, 1'b0);
    chk("midburst_busy", 64'(busy), 64'd1);
    pulse_rst();
    chk("midburst_rst_busy", 64'(busy), 64'd0);
    chk("midburst_rst_ops", 64'(adder_ops == '0), 64'd1);
    chk("midburst_rst_in_ready", 64'(in_ready), 64'd1);
    vx = '{2, 16'd4, 16'd2, 1'b1, 1'b0, 0, 1'b0, 22'd10, 6'd2};
    run_vec(vx, 10);

    // Reset during COMPUTE: no result may appear.
    beat(16'd1, 1'b0);
    beat(16'd2, 1'b0);
    beat(16'd3, 1'b1);
    chk("compute_in_ready", 64'(in_ready), 64'd0);
    pulse_rst();
    chk("compute_rst_in_ready", 64'(in_ready), 64'd1);
    chk("compute_rst_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("compute_rst_no_valid", 64'(seen), 64'd0);
    vx = '{1, 16'd7, 16'd0, 1'b1, 1'b0, 0, 1'b0, 22'd7, 6'd1};
    run_vec(vx, 11);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
